// File: rtl/instr_fetch_queue.sv
// Byte-serial instruction fetcher that feeds a first-word-fall-through word queue.
// Define IFQ_BYPASS_EN to let a word that completes into an empty queue appear on instr in the same cycle.
module instr_fetch_queue #(
  parameter int         DEPTH   = 4,
  parameter logic [6:0] PCSTART = 7'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [6:0]                 imem_addr,
  input  logic                       imem_ack,
  input  logic [7:0]                 imem_byte,
  input  logic                       redirect,
  input  logic [6:0]                 redirect_addr,
  output logic                       instr_valid,
  output logic [31:0]                instr,
  output logic [6:0]                 instr_pc_inc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {S_FETCH, S_FULL} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] count_q, count_d;
  logic [1:0]    byte_cnt;
  logic [6:0]    fetch_pc;
  logic [23:0]   part;
  logic [31:0]   mem_w  [DEPTH];
  logic [6:0]    mem_pc [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  logic        accept, last, push, pop;
  logic [31:0] full_word;
  logic [6:0]  next_pc;

  // Reset gating keeps imem_req low while reset is held, even though state is FETCH.
  assign imem_req  = reset & (state_q == S_FETCH) & ~redirect;
  assign imem_addr = fetch_pc + {5'd0, byte_cnt};
  assign accept    = imem_req & imem_ack;
  assign last      = accept & (byte_cnt == 2'd3);
  assign full_word = {part, imem_byte};
  assign next_pc   = fetch_pc + 7'd4;
  assign pop       = (count_q != '0) & instr_ready & ~redirect;
  assign count     = count_q;

`ifdef IFQ_BYPASS_EN
  logic byp;
  assign byp          = last & (count_q == '0);
  assign instr_valid  = (count_q != '0) | byp;
  assign instr        = byp ? full_word : mem_w[rd_ptr];
  assign instr_pc_inc = byp ? next_pc : mem_pc[rd_ptr];
  assign push         = last & ~(byp & instr_ready);
`else
  assign instr_valid  = (count_q != '0);
  assign instr        = mem_w[rd_ptr];
  assign instr_pc_inc = mem_pc[rd_ptr];
  assign push         = last;
`endif

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    if (redirect) count_d = '0;
    state_d = (count_d == CW'(DEPTH)) ? S_FULL : S_FETCH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= 2'd0;
      fetch_pc <= PCSTART;
      part     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_w[i]  <= '0;
        mem_pc[i] <= '0;
      end
    end else if (redirect) begin
      byte_cnt <= 2'd0;
      fetch_pc <= redirect_addr;
      part     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    part[23:16] <= imem_byte;
          2'd1:    part[15:8]  <= imem_byte;
          2'd2:    part[7:0]   <= imem_byte;
          default: ;
        endcase
      end
      if (last) fetch_pc <= next_pc;
      if (push) begin
        mem_w[wr_ptr]  <= full_word;
        mem_pc[wr_ptr] <= next_pc;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, on ports clk and reset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- DEPTH, 4, queue entries; power of two, 2..8.
- PCSTART, 7'd0, byte address of the first fetch after reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- reset, in, 1, active-low asynchronous reset.
- imem_req, out, 1, byte fetch request.
- imem_addr, out, 7, byte address of the request.
- imem_ack, in, 1, byte accepted and imem_byte valid this cycle.
- imem_byte, in, 8, returned instruction byte.
- redirect, in, 1, taken jump: flush and refetch.
- redirect_addr, in, 7, jump target byte address.
- instr_valid, out, 1, head entry valid.
- instr, out, 32, head instruction word.
- instr_pc_inc, out, 7, head word address + 4, mod 128.
- instr_ready, in, 1, downstream (IF/ID enable) consumes head.
- count, out, $clog2(DEPTH)+1, occupied entries.

Function
REQ-004 The block SHALL fetch instructions byte-serially, big-endian: byte_cnt 0..3 maps to instr[31:24], [23:16], [15:8], [7:0].
REQ-005 imem_addr SHALL equal fetch_pc + byte_cnt, mod 128; fetch_pc advances by 4 and wraps from 124 to 0.
REQ-006 A byte SHALL be captured only on a cycle where imem_req and imem_ack are both high; byte_cnt then increments, wrapping 3 to 0.
REQ-007 On acceptance of byte 3, the block SHALL push {word, fetch_pc+4} into the queue and set fetch_pc to fetch_pc+4.
REQ-008 The FSM SHALL have two states:
- FETCH (count<DEPTH): imem_req = ~redirect.
- FULL (count==DEPTH): imem_req = 0.
- Transitions evaluate count after this cycle's push and pop.
REQ-009 A partial word (byte_cnt≠0) SHALL be held unchanged while the FSM is in FULL, and fetching SHALL resume at the same byte_cnt.
REL-010 The queue SHALL be first-word-fall-through with registered storage: instr_valid = (count≠0), and instr/instr_pc_inc show the head entry.
REQ-011 A pop SHALL occur when instr_valid and instr_ready are both high; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-012 instr and instr_pc_inc SHALL be held stable while instr_valid=1 and instr_ready=0.
REQ-013 On redirect=1 at a clock edge, the block SHALL:
- set count to 0 and discard the partial word;
- set byte_cnt to 0 and fetch_pc to redirect_addr, used as-is with no alignment;
- ignore any push or pop in that same cycle.
REQ-014 When redirect=1, imem_req SHALL be 0 in that same cycle, and any imem_ack in that cycle SHALL be ignored.
REQ-015 Latency, without the bypass: with imem_ack tied high, the first instr_valid SHALL appear in the 5th cycle after reset release (4 byte cycles plus 1 register cycle).
REQ-016 Sustained throughput SHALL be 1 word per 4 cycles with imem_ack=1 and instr_ready=1, with no lost bytes at queue boundaries.

Reset
REQ-017 While reset=0, the block SHALL asynchronously force:
- count=0, byte_cnt=0, fetch_pc=PCSTART, state=FETCH;
- instr_valid=0, instr=0, instr_pc_inc=0, imem_req=0.
REQ-018 The first fetch after reset SHALL be issued on the first rising edge after reset deasserts, with imem_addr=PCSTART.
REQ-019 If reset asserts mid-word or mid-operation, all in-flight bytes and queue contents SHALL be discarded.

Configuration
REQ-020 The bypass SHALL be controlled by the macro IFQ_BYPASS_EN.
- Defined: when the queue is empty and byte 3 is accepted, instr_valid=1 in that same cycle, with instr = {assembled bytes 0..2, imem_byte}. If instr_ready=1, the word is consumed and not stored; otherwise it is stored normally.
- Defined: first-valid latency becomes the 4th cycle after reset release.
- Not defined: there is no combinational path from imem_byte or imem_ack to the instr outputs.

Verification
REQ-021 Reset release, imem_ack=1, instr_ready=1, memory bytes 0..7 = 11..18:
- imem_addr sequence 0,1,2,3,4,...;
- instr=32'h11121314 with instr_pc_inc=4, then 32'h15161718 with instr_pc_inc=8.
REQ-022 instr_ready=0 with DEPTH=4:
- after 4 words, count=4, FSM in FULL, imem_req=0;
- raising instr_ready for 1 cycle gives count=3 and fetch resumes at the held byte_cnt.
REQ-023 Redirect to 7'd40 during byte_cnt=2 with the queue holding 2 entries:
- next cycle count=0, imem_addr=40;
- the next delivered word's instr_pc_inc=44.
REQ-024 fetch_pc=124, full word fetched: instr_pc_inc=0 and the next imem_addr=0.
REQ-025 imem_ack toggling 1,0,1,0: only acked bytes are captured, and the word assembles correctly after 4 acks.
REQ-026 Reset asserted with byte_cnt=1 and count=3: outputs go to zero immediately, asynchronously to clk.
